fetch_queue: RTL and testbench

//  Instruction fetch queue between the IF stage and the ID stage.

---
 rtl/fetch_queue.sv | 163 ++++++++++++++++
 tb/tb_fetch_queue.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch queue between the IF and ID stages. It buffers
//   {pc, inst} pairs from IF so that ICache stalls and ID back-pressure do not
//   stall each other. A branch redirect from EX (flush) discards every entry.
//
// Parameters
//   DEPTH      number of entries (power of two, >= 2)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   IF presents a fetched instruction
//   in_pc      PC of the fetched instruction
//   in_inst    fetched instruction word
//   in_ready   queue can accept an entry (not full)
//   flush      branch redirect; empties the queue at the next edge
//   out_valid  head entry valid for ID
//   out_pc     head entry PC (zero when !out_valid)
//   out_inst   head entry instruction (zero when !out_valid)
//   out_ready  ID consumes the head entry this cycle
//   count      number of stored entries
//
// Build option
//   FETCH_QUEUE_BYPASS_EN  when defined, an instruction arriving at an empty
//                          queue is presented to ID in the same cycle, and is
//                          not stored if ID takes it in that cycle.
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_inst,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_inst,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q,  count_d;

    logic            empty;
    logic            full;
    logic            bypass_avail;
    logic            bypass_take;
    logic            push;
    logic            pop;
    logic            wr_en;
    logic            rd_en;

    // Handshake and output datapath
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        // in_ready depends on the stored count only; a pop in a full cycle
        // does not open a slot for a push in that same cycle.
        in_ready = !full;

`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_avail = empty && in_valid && !flush;
`else
        bypass_avail = 1'b0;
`endif

        out_valid = !empty || bypass_avail;
        if (!empty) begin
            out_pc   = mem_q[rd_ptr_q].pc;
            out_inst = mem_q[rd_ptr_q].inst;
        end else if (bypass_avail) begin
            out_pc   = in_pc;
            out_inst = in_inst;
        end else begin
            out_pc   = '0;
            out_inst = '0;
        end

        push = in_valid  && in_ready  && !flush;
        pop  = out_valid && out_ready && !flush;

        // A bypassed entry taken by ID in the same cycle never touches
        // storage: neither pointer moves and count stays at zero.
        bypass_take = bypass_avail && out_ready;
        wr_en       = push && !bypass_take;
        rd_en       = pop  && !bypass_take;
    end

    // Next-state for pointers, count and storage
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q] = '{pc: in_pc, inst: in_inst};
                // DEPTH is a power of two, so AW-bit wrap is DEPTH-1 -> 0.
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({wr_en, rd_en})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage contents are don't-care after reset; no reset needed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count = count_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(wr_en && full))
                else $error("fetch_queue: push while full");
            assert (!(rd_en && empty))
                else $error("fetch_queue: pop while empty");
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Directed self-checking bench for fetch_queue (DEPTH = 4): reset (including
//   asynchronous reset mid-operation), fill/drain order, wrap-around with
//   toggling back-pressure, full with simultaneous pop, flush, and the
//   same-cycle bypass behaviour of either build.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    fetch_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return (pc << 8) | 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                failures++;
                $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
            end
    endtask

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst_of(pc);
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mq[$];
        int          pushed;
        int          popped;
        logic        v;
        logic        ordy;
        logic [31:0] pc;
        logic        acc_push;

        // ---------------- reset ----------------
        rst = 1'b0;
        idle();
        #2 rst = 1'b1;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_count",     count,     0);
        check("rst_out_pc",    out_pc,    0);
        check("rst_out_inst",  out_inst,  0);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Asynchronous reset in the middle of a cycle with entries stored
        drive(1'b1, 32'h40, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'h44, 1'b0, 1'b0);
        cycle();
        idle();
        check("mid_pre_count", count, 2);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_pc",    out_pc,    0);
        check("mid_rst_out_inst",  out_inst,  0);
        check("mid_rst_in_ready",  in_ready,  1);
        check("mid_rst_count",     count,     0);
        cycle();
        rst = 1'b0;
        cycle();

        // ---------------- fill / drain ----------------
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
            check("fill_in_ready", in_ready, 1);
`ifndef FETCH_QUEUE_BYPASS_EN
            if (i == 0) check("fill_latency_valid", out_valid, 0);
`endif
            cycle();
            check("fill_count", count, 32'(i + 1));
            check("fill_head_pc", out_pc, 32'h0);
        end
        idle();
        check("full_count",    count,    4);
        check("full_in_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            check("drain_valid", out_valid, 1);
            check("drain_pc",    out_pc,    32'(i * 4));
            check("drain_inst",  out_inst,  inst_of(32'(i * 4)));
            cycle();
        end
        idle();
        check("drained_count", count,     0);
        check("drained_valid", out_valid, 0);
        check("drained_pc",    out_pc,    0);

        // ---------------- wrap-around, toggling out_ready ----------------
        pushed = 0;
        popped = 0;
        for (int c = 0; c < 60 && popped < 10; c++) begin
            v    = (pushed < 10);
            pc   = 32'h200 + 32'(pushed * 4);
            ordy = (c % 2 == 1);
            drive(v, pc, ordy, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
            check("wrap_valid", out_valid, (mq.size() != 0) || v);
            if (mq.size() == 0 && v) check("wrap_byp_pc", out_pc, pc);
`else
            check("wrap_valid", out_valid, mq.size() != 0);
`endif
            if (mq.size() != 0) check("wrap_order", out_pc, mq[0]);

            acc_push = v && (mq.size() < 4);
`ifdef FETCH_QUEUE_BYPASS_EN
            if (mq.size() == 0 && v && ordy) begin
                pushed++;
                popped++;
                acc_push = 1'b0;
            end else
`endif
            if (mq.size() != 0 && ordy) begin
                void'(mq.pop_front());
                popped++;
            end
            if (acc_push) begin
                mq.push_back(pc);
                pushed++;
            end
            cycle();
            check("wrap_count", count, mq.size());
            check("wrap_count_max", count <= 3'd4, 1);
        end
        idle();
        check("wrap_all_popped", popped, 10);
        check("wrap_empty",      count,  0);

        // ---------------- full with simultaneous pop ----------------
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 32'h4F0, 1'b1, 1'b0);
        check("fullpop_in_ready", in_ready, 0);
        check("fullpop_head",     out_pc,   32'h300);
        cycle();
        check("fullpop_count", count,  3);
        check("fullpop_next",  out_pc, 32'h304);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cycle();
        check("pop_to_two", count, 2);
        drive(1'b1, 32'h400, 1'b1, 1'b0);
        cycle();
        check("pushpop_count", count,  2);
        check("pushpop_head",  out_pc, 32'h30C);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("tail_pc0", out_pc, 32'h30C);
        cycle();
        check("tail_pc1",   out_pc,   32'h400);
        check("tail_inst1", out_inst, inst_of(32'h400));
        cycle();
        idle();
        check("tail_empty", count, 0);

        // ---------------- flush ----------------
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h500 + 32'(i * 4), 1'b0, 1'b0);
            cycle();
        end
        idle();
        check("preflush_count", count, 3);
        drive(1'b1, 32'h5F0, 1'b1, 1'b1);
        cycle();
        idle();
        check("flush_count",    count,     0);
        check("flush_valid",    out_valid, 0);
        check("flush_in_ready", in_ready,  1);
        check("flush_pc",       out_pc,    0);
        drive(1'b1, 32'h600, 1'b0, 1'b0);
        cycle();
        idle();
        check("postflush_count", count,  1);
        check("postflush_pc",    out_pc, 32'h600);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cycle();
        idle();
        check("postflush_empty", count, 0);

        // Flush while full
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h700 + 32'(i * 4), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        cycle();
        idle();
        check("flushfull_count",    count,     0);
        check("flushfull_in_ready", in_ready,  1);
        check("flushfull_valid",    out_valid, 0);

        // ---------------- same-cycle visibility (bypass or not) ----------------
        drive(1'b1, 32'h100, 1'b1, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
        check("byp_same_valid", out_valid, 1);
        check("byp_same_pc",    out_pc,    32'h100);
        check("byp_same_inst",  out_inst,  inst_of(32'h100));
        cycle();
        idle();
        check("byp_next_count", count,     0);
        check("byp_next_valid", out_valid, 0);
`else
        check("nobyp_same_valid", out_valid, 0);
        check("nobyp_same_pc",    out_pc,    0);
        cycle();
        idle();
        check("nobyp_next_valid", out_valid, 1);
        check("nobyp_next_pc",    out_pc,    32'h100);
        check("nobyp_next_count", count,     1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cycle();
        idle();
        check("nobyp_drained", count, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
